// File: rtl/fir_coeff_sequencer_if.sv
// Host/filter-side bundle for the FIR coefficient sequencer.
// The master modport drives host writes and commands; the slave modport drives the filter bus.
interface fir_coeff_sequencer_if #(
  parameter int W  = 32,
  parameter int AW = 7
);
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_wdata;
  logic          start;
  logic          abort;
  logic [W-1:0]  coeff_out;
  logic          shift_en;
  logic          bus_sel;
  logic          sample_hold;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          wr_err;

  modport master (
    output host_we,
    output host_addr,
    output host_wdata,
    output start,
    output abort,
    input  coeff_out,
    input  shift_en,
    input  bus_sel,
    input  sample_hold,
    input  busy,
    input  done,
    input  aborted,
    input  wr_err
  );

  modport slave (
    input  host_we,
    input  host_addr,
    input  host_wdata,
    input  start,
    input  abort,
    output coeff_out,
    output shift_en,
    output bus_sel,
    output sample_hold,
    output busy,
    output done,
    output aborted,
    output wr_err
  );
endinterface

// File: rtl/fir_coeff_sequencer.sv
// Coefficient buffer plus LOAD/SETTLE streamer for the 64-tap FIR chain.
// Every output is registered and computed from the next state.
module fir_coeff_sequencer #(
  parameter int NTAPS = 64,
  parameter int W     = 32,
  parameter int AW    = 7
) (
  input  logic                 clk_coeff,
  input  logic                 reset,
  fir_coeff_sequencer_if.slave cs
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NTAPS);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [W-1:0]  mem_q [0:NTAPS];
  logic [W-1:0]  mem_d [0:NTAPS];

  logic [W-1:0]  coeff_out_q, coeff_out_d;
  logic          shift_en_q, shift_en_d;
  logic          bus_sel_q, bus_sel_d;
  logic          sample_hold_q, sample_hold_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          wr_err_q, wr_err_d;
  logic          wr_ok;

  // A write in the start cycle lands in mem_d, so the stream sees it.
  always_comb begin
    wr_ok = cs.host_we
          && (state_q == S_IDLE)
          && (cs.host_addr <= LAST);
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[cs.host_addr] = cs.host_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cs.start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (cs.abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (idx_q == LAST) begin
          state_d = S_SETTLE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_SETTLE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    shift_en_d    = (state_d == S_LOAD);
    bus_sel_d     = (state_d != S_IDLE);
    sample_hold_d = (state_d != S_IDLE);
    busy_d        = (state_d != S_IDLE);
    wr_err_d      = cs.host_we && !wr_ok;
    coeff_out_d   = '0;
    if (state_d == S_LOAD) begin
      coeff_out_d = mem_d[idx_d];
    end
  end

  always_ff @(posedge clk_coeff) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      mem_q         <= '{default: '0};
      coeff_out_q   <= '0;
      shift_en_q    <= 1'b0;
      bus_sel_q     <= 1'b0;
      sample_hold_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      mem_q         <= mem_d;
      coeff_out_q   <= coeff_out_d;
      shift_en_q    <= shift_en_d;
      bus_sel_q     <= bus_sel_d;
      sample_hold_q <= sample_hold_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      wr_err_q      <= wr_err_d;
    end
  end

  assign cs.coeff_out   = coeff_out_q;
  assign cs.shift_en    = shift_en_q;
  assign cs.bus_sel     = bus_sel_q;
  assign cs.sample_hold = sample_hold_q;
  assign cs.busy        = busy_q;
  assign cs.done        = done_q;
  assign cs.aborted     = aborted_q;
  assign cs.wr_err      = wr_err_q;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Directed bench for fir_coeff_sequencer.
// Inputs change and outputs are sampled on the falling edge of clk_coeff.
module tb_fir_coeff_sequencer;
  localparam int NTAPS = 64;
  localparam int W     = 32;
  localparam int AW    = 7;

  logic clk_coeff = 1'b0;
  logic reset     = 1'b1;
  always #5 clk_coeff = ~clk_coeff;

  fir_coeff_sequencer_if #(.W(W), .AW(AW)) ifc ();

  fir_coeff_sequencer #(.NTAPS(NTAPS), .W(W), .AW(AW)) dut (
    .clk_coeff (clk_coeff),
    .reset     (reset),
    .cs        (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_mem [0:NTAPS];

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    ifc.host_we    = 1'b1;
    ifc.host_addr  = a;
    ifc.host_wdata = d;
    @(negedge clk_coeff);
    ifc.host_we = 1'b0;
    if (a <= AW'(NTAPS)) exp_mem[a] = d;
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    @(negedge clk_coeff);
    ifc.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+6:0] outs;
    reset = 1'b1;
    @(negedge clk_coeff);
    @(negedge clk_coeff);
    outs = {ifc.coeff_out, ifc.shift_en, ifc.bus_sel, ifc.sample_hold,
            ifc.busy, ifc.done, ifc.aborted, ifc.wr_err};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL reset_outs got=%0h exp=0", outs);
    end
    reset = 1'b0;
    @(negedge clk_coeff);
    n_cmp++;
    if (ifc.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_busy got=%b exp=0", ifc.busy);
    end
  endtask

  task automatic test_stream();
    int sh, bsy, bsel, hold, done_at, first, last;
    logic done_busy, done_bsel;
    sh = 0; bsy = 0; bsel = 0; hold = 0;
    done_at = -1; first = -1; last = -1;
    done_busy = 1'bx; done_bsel = 1'bx;
    for (int i = 0; i <= NTAPS; i++) begin
      wr(AW'(i), W'(i + 1));
      n_cmp++;
      if (ifc.wr_err !== 1'b0) begin
        n_bad++;
        $display("FAIL stream_wr_err i=%0d got=%b exp=0", i, ifc.wr_err);
      end
    end
    pulse_start();
    for (int c = 1; c <= 70; c++) begin
      if (ifc.shift_en) begin
        if (sh <= NTAPS) begin
          n_cmp++;
          if (ifc.coeff_out !== exp_mem[sh]) begin
            n_bad++;
            $display("FAIL stream_word%0d got=%0h exp=%0h", sh, ifc.coeff_out, exp_mem[sh]);
          end
        end
        if (first < 0) first = c;
        last = c;
        sh++;
      end
      if (ifc.busy) bsy++;
      if (ifc.bus_sel) bsel++;
      if (ifc.sample_hold) hold++;
      if (ifc.done) begin
        done_at = c;
        done_busy = ifc.busy;
        done_bsel = ifc.bus_sel;
      end
      @(negedge clk_coeff);
    end
    n_cmp++;
    if (sh !== 65) begin n_bad++; $display("FAIL stream_shifts got=%0d exp=65", sh); end
    n_cmp++;
    if (first !== 1 || last !== 65) begin
      n_bad++;
      $display("FAIL stream_window got=%0d..%0d exp=1..65", first, last);
    end
    n_cmp++;
    if (done_at !== 67) begin n_bad++; $display("FAIL stream_done_at got=%0d exp=67", done_at); end
    n_cmp++;
    if (bsy !== 66 || bsel !== 66 || hold !== 66) begin
      n_bad++;
      $display("FAIL stream_hold_len got=%0d/%0d/%0d exp=66", bsy, bsel, hold);
    end
    n_cmp++;
    if (done_busy !== 1'b0 || done_bsel !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_done_idle got=%b%b exp=00", done_busy, done_bsel);
    end
  endtask

  task automatic test_busy_ignore();
    int sh, errs, err_at, dones, done_at;
    sh = 0; errs = 0; err_at = -1; dones = 0; done_at = -1;
    pulse_start();
    for (int c = 1; c <= 75; c++) begin
      if (ifc.shift_en) begin
        if (sh <= NTAPS) begin
          n_cmp++;
          if (ifc.coeff_out !== exp_mem[sh]) begin
            n_bad++;
            $display("FAIL busy_word%0d got=%0h exp=%0h", sh, ifc.coeff_out, exp_mem[sh]);
          end
        end
        sh++;
      end
      if (ifc.wr_err) begin errs++; err_at = c; end
      if (ifc.done) begin dones++; done_at = c; end
      if (c == 10) begin
        ifc.host_we = 1'b1; ifc.host_addr = 7'd5;
        ifc.host_wdata = 32'h0000DEAD; ifc.start = 1'b1;
      end
      if (c == 11) begin ifc.host_we = 1'b0; ifc.start = 1'b0; end
      @(negedge clk_coeff);
    end
    n_cmp++;
    if (errs !== 1 || err_at !== 11) begin
      n_bad++;
      $display("FAIL busy_wr_err got=%0d@%0d exp=1@11", errs, err_at);
    end
    n_cmp++;
    if (sh !== 65) begin n_bad++; $display("FAIL busy_shifts got=%0d exp=65", sh); end
    n_cmp++;
    if (dones !== 1 || done_at !== 67) begin
      n_bad++;
      $display("FAIL busy_done got=%0d@%0d exp=1@67", dones, done_at);
    end
  endtask

  task automatic test_abort();
    int sh, abs, ab_at, dones;
    logic bsel_after;
    sh = 0; abs = 0; ab_at = -1; dones = 0; bsel_after = 1'bx;
    pulse_start();
    for (int c = 1; c <= 75; c++) begin
      if (ifc.shift_en) sh++;
      if (ifc.aborted) begin abs++; ab_at = c; end
      if (ifc.done) dones++;
      if (c == 21) bsel_after = ifc.bus_sel;
      if (c == 20) ifc.abort = 1'b1;
      if (c == 21) ifc.abort = 1'b0;
      @(negedge clk_coeff);
    end
    n_cmp++;
    if (sh !== 20) begin n_bad++; $display("FAIL abort_shifts got=%0d exp=20", sh); end
    n_cmp++;
    if (abs !== 1 || ab_at !== 21) begin
      n_bad++;
      $display("FAIL abort_pulse got=%0d@%0d exp=1@21", abs, ab_at);
    end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    n_cmp++;
    if (bsel_after !== 1'b0) begin n_bad++; $display("FAIL abort_bus_sel got=%b exp=0", bsel_after); end
  endtask

  task automatic test_reset_mid();
    int sh, dones, abs, done_at;
    logic [W+6:0] outs;
    sh = 0; dones = 0; abs = 0; outs = 'x;
    pulse_start();
    for (int c = 1; c <= 40; c++) begin
      if (ifc.shift_en) sh++;
      if (ifc.done) dones++;
      if (ifc.aborted) abs++;
      if (c == 31) outs = {ifc.coeff_out, ifc.shift_en, ifc.bus_sel, ifc.sample_hold,
                           ifc.busy, ifc.done, ifc.aborted, ifc.wr_err};
      if (c == 30) reset = 1'b1;
      if (c == 31) reset = 1'b0;
      @(negedge clk_coeff);
    end
    for (int i = 0; i <= NTAPS; i++) exp_mem[i] = '0;
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL rstmid_outs got=%0h exp=0", outs); end
    n_cmp++;
    if (sh !== 30 || dones !== 0 || abs !== 0) begin
      n_bad++;
      $display("FAIL rstmid_pulses got=sh%0d d%0d a%0d exp=sh30 d0 a0", sh, dones, abs);
    end
    sh = 0; done_at = -1;
    pulse_start();
    for (int c = 1; c <= 70; c++) begin
      if (ifc.shift_en) begin
        n_cmp++;
        if (ifc.coeff_out !== '0) begin
          n_bad++;
          $display("FAIL rstmid_zero%0d got=%0h exp=0", sh, ifc.coeff_out);
        end
        sh++;
      end
      if (ifc.done) done_at = c;
      @(negedge clk_coeff);
    end
    n_cmp++;
    if (sh !== 65 || done_at !== 67) begin
      n_bad++;
      $display("FAIL rstmid_restream got=%0d,%0d exp=65,67", sh, done_at);
    end
  endtask

  task automatic test_addr_bounds();
    int sh;
    logic [W-1:0] last_word;
    sh = 0; last_word = 'x;
    wr(7'd65, 32'h12345678);
    n_cmp++;
    if (ifc.wr_err !== 1'b1) begin n_bad++; $display("FAIL bounds_err65 got=%b exp=1", ifc.wr_err); end
    @(negedge clk_coeff);
    n_cmp++;
    if (ifc.wr_err !== 1'b0) begin n_bad++; $display("FAIL bounds_err_pulse got=%b exp=0", ifc.wr_err); end
    wr(7'd127, 32'hCAFEF00D);
    n_cmp++;
    if (ifc.wr_err !== 1'b1) begin n_bad++; $display("FAIL bounds_err127 got=%b exp=1", ifc.wr_err); end
    wr(7'd64, 32'h00000800);
    n_cmp++;
    if (ifc.wr_err !== 1'b0) begin n_bad++; $display("FAIL bounds_ok64 got=%b exp=0", ifc.wr_err); end
    pulse_start();
    for (int c = 1; c <= 70; c++) begin
      if (ifc.shift_en) begin
        if (sh <= NTAPS) begin
          n_cmp++;
          if (ifc.coeff_out !== exp_mem[sh]) begin
            n_bad++;
            $display("FAIL bounds_word%0d got=%0h exp=%0h", sh, ifc.coeff_out, exp_mem[sh]);
          end
        end
        last_word = ifc.coeff_out;
        sh++;
      end
      @(negedge clk_coeff);
    end
    n_cmp++;
    if (last_word !== 32'h00000800) begin
      n_bad++;
      $display("FAIL bounds_last got=%0h exp=800", last_word);
    end
  endtask

  task automatic test_back_to_back();
    int sh, dones, d1, d2;
    logic [W-1:0] w1, w68;
    logic gap, err1;
    sh = 0; dones = 0; d1 = -1; d2 = -1;
    w1 = 'x; w68 = 'x; gap = 1'b0; err1 = 1'bx;
    ifc.start = 1'b1; ifc.host_we = 1'b1;
    ifc.host_addr = 7'd0; ifc.host_wdata = 32'h7FFFFFFF;
    exp_mem[0] = 32'h7FFFFFFF;
    @(negedge clk_coeff);
    ifc.start = 1'b0; ifc.host_we = 1'b0;
    for (int c = 1; c <= 140; c++) begin
      if (c == 1) begin w1 = ifc.coeff_out; err1 = ifc.wr_err; end
      if (c == 68) w68 = ifc.coeff_out;
      if ((c == 66 || c == 67) && ifc.shift_en) gap = 1'b1;
      if (ifc.shift_en) begin
        n_cmp++;
        if (ifc.coeff_out !== exp_mem[sh % (NTAPS + 1)]) begin
          n_bad++;
          $display("FAIL b2b_word%0d got=%0h exp=%0h", sh, ifc.coeff_out, exp_mem[sh % (NTAPS + 1)]);
        end
        sh++;
      end
      if (ifc.done) begin
        dones++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
      if (c == 67) ifc.start = 1'b1;
      if (c == 68) ifc.start = 1'b0;
      @(negedge clk_coeff);
    end
    n_cmp++;
    if (w1 !== 32'h7FFFFFFF || err1 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first got=%0h err=%b exp=7fffffff err=0", w1, err1);
    end
    n_cmp++;
    if (w68 !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL b2b_second got=%0h exp=7fffffff", w68); end
    n_cmp++;
    if (sh !== 130 || gap !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_shifts got=%0d gap=%b exp=130 gap=0", sh, gap);
    end
    n_cmp++;
    if (dones !== 2 || d1 !== 67 || d2 !== 134) begin
      n_bad++;
      $display("FAIL b2b_done got=%0d@%0d,%0d exp=2@67,134", dones, d1, d2);
    end
  endtask

  initial begin
    ifc.host_we = 1'b0;
    ifc.host_addr = '0;
    ifc.host_wdata = '0;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    for (int i = 0; i <= NTAPS; i++) exp_mem[i] = '0;
    test_reset();
    test_stream();
    test_busy_ignore();
    test_abort();
    test_reset_mid();
    test_addr_bounds();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
